// File: rtl/sram_fill_writer_pkg.sv
// Shared widths, defaults and FSM encoding for the instruction-SRAM fill writer.
package sram_fill_writer_pkg;

    localparam int unsigned DATA_W         = 72;  // 8 instructions x 9 bits
    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fill_state_e;

    // A length of zero encodes a full sweep of the address space.
    function automatic logic [ADDR_W:0] fill_len(input logic [ADDR_W-1:0] len);
        logic [ADDR_W:0] n;
        n = {1'b0, len};
        if (len == '0) begin
            n = {1'b1, {ADDR_W{1'b0}}};
        end
        return n;
    endfunction

endpackage

// File: rtl/sram_fill_writer_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and async active-low clear.
module sram_fill_writer_sync_fifo #(
    parameter int unsigned Width = 72,
    parameter int unsigned Depth = 4   // power of 2, at least 2
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW:0]    r_wr_ptr;
    logic [PtrW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                       (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
    assign w_do_push = i_push && !o_full;   // a same-cycle pop does not make room
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[PtrW-1:0]];

    // Pointer update; clearing the pointers discards all contents.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PtrW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sram_fill_writer.sv
// Write-side controller for the 8-bank instruction SRAM: buffers a fill stream and
// shares the single SRAM port with fetch reads, forcing a write after a bounded stall.
module sram_fill_writer
    import sram_fill_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned STALL_MAX  = 16
) (
    input  logic              i_fire,
    input  logic              rst,
    input  logic              i_fillReq,
    input  logic [ADDR_W-1:0] i_baseAddr,
    input  logic [ADDR_W-1:0] i_fillLen,
    input  logic              i_inValid,
    input  logic [DATA_W-1:0] i_inData,
    output logic              o_inReady,
    input  logic              i_readReq,
    output logic              o_read_en,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_writeAddr,
    output logic [DATA_W-1:0] o_writeData,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned StallW = $clog2(STALL_MAX + 1);

    fill_state_e       r_state;
    fill_state_e       w_state_next;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_rem_wr;
    logic [ADDR_W:0]   r_rem_in;
    logic [StallW-1:0] r_stall_cnt;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_in_ready;
    logic              w_push;
    logic              w_write_en;
    logic              w_starved;

    assign w_starved = (r_stall_cnt == StallW'(STALL_MAX));
    assign w_push    = i_inValid && w_in_ready;

    sram_fill_writer_sync_fifo #(
        .Width (DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_fire),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_inData),
        .i_pop   (w_write_en),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus handshake and port arbitration; reads win unless starved.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_write_en   = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_fillReq) w_state_next = StFill;
            end
            StFill: begin
                o_busy     = 1'b1;
                w_in_ready = !w_full && (r_rem_in != '0);
                w_write_en = !w_empty && (!i_readReq || w_starved);
                if (w_write_en && (r_rem_wr == (ADDR_W+1)'(1))) w_state_next = StDone;
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Address, remaining-count and starvation counters.
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            r_cur_addr  <= '0;
            r_rem_wr    <= '0;
            r_rem_in    <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == StIdle) begin
            if (i_fillReq) begin
                r_cur_addr  <= i_baseAddr;
                r_rem_wr    <= fill_len(i_fillLen);
                r_rem_in    <= fill_len(i_fillLen);
                r_stall_cnt <= '0;
            end
        end else if (r_state == StFill) begin
            if (w_push) r_rem_in <= r_rem_in - 1'b1;
            if (w_write_en) begin
                r_cur_addr  <= r_cur_addr + 1'b1;   // wraps modulo 2^ADDR_W
                r_rem_wr    <= r_rem_wr - 1'b1;
                r_stall_cnt <= '0;
            end else if (!w_empty && i_readReq && !w_starved) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Address/data forced to zero when idle so the port reads quiet outside a write.
    assign o_inReady   = w_in_ready;
    assign o_write_en  = w_write_en;
    assign o_read_en   = i_readReq && !w_write_en;
    assign o_writeAddr = w_write_en ? r_cur_addr : '0;
    assign o_writeData = w_write_en ? w_head : '0;

endmodule

// File: tb/tb_sram_fill_writer.sv
// Directed bench for sram_fill_writer with a small cycle model of the FIFO and stall counter.
module tb_sram_fill_writer;

    localparam int Depth = 4;
    localparam int Stall = 16;

    logic        i_fire = 1'b0;
    logic        rst = 1'b0;
    logic        i_fillReq = 1'b0;
    logic [7:0]  i_baseAddr = '0;
    logic [7:0]  i_fillLen = '0;
    logic        i_inValid = 1'b0;
    logic [71:0] i_inData = '0;
    logic        o_inReady;
    logic        i_readReq = 1'b0;
    logic        o_read_en;
    logic        o_write_en;
    logic [7:0]  o_writeAddr;
    logic [71:0] o_writeData;
    logic        o_busy;
    logic        o_done;

    int n_vec = 0;
    int n_err = 0;

    sram_fill_writer dut (
        .i_fire      (i_fire),
        .rst         (rst),
        .i_fillReq   (i_fillReq),
        .i_baseAddr  (i_baseAddr),
        .i_fillLen   (i_fillLen),
        .i_inValid   (i_inValid),
        .i_inData    (i_inData),
        .o_inReady   (o_inReady),
        .i_readReq   (i_readReq),
        .o_read_en   (o_read_en),
        .o_write_en  (o_write_en),
        .o_writeAddr (o_writeAddr),
        .o_writeData (o_writeData),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_fire = ~i_fire;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Payload tagged with fill base and index so stale words from another fill are caught.
    function automatic logic [71:0] word(input logic [7:0] base, input int idx);
        return {base, 32'hC0DE_0000 | 32'(idx), 32'(idx * 7 + 3)};
    endfunction

    // Drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic tick(input logic fr, input logic [7:0] ba, input logic [7:0] fl,
                        input logic v, input logic [71:0] d, input logic rr);
        @(negedge i_fire);
        i_fillReq  = fr;
        i_baseAddr = ba;
        i_fillLen  = fl;
        i_inValid  = v;
        i_inData   = d;
        i_readReq  = rr;
        #1;
    endtask

    // mode 0: no reads, valid until len; 1: reads always; 2: random reads/valid;
    // 3: no reads, valid held high past the fill length.
    task automatic run_fill(input logic [7:0] base, input logic [7:0] len, input int mode,
                            input int abort_after, output int first_wr, output int max_occ,
                            output int n_hs);
        int n, sent, nw, occ, st, rem_in, cyc, last_wr;
        logic rr, v, exp_wr, hs;
        bit finished;
        n = (len == 8'd0) ? 256 : int'(len);
        sent = 0; nw = 0; occ = 0; st = 0; rem_in = n; cyc = 0; last_wr = -10;
        first_wr = -1; max_occ = 0; finished = 0;
        tick(1'b1, base, len, 1'b0, '0, 1'b0);
        check("req_busy", o_busy, 1'b0);
        check("req_ready", o_inReady, 1'b0);
        while (!finished && cyc < 3000) begin
            rr = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            v  = (mode == 3) ? 1'b1 :
                 (mode == 2) ? (sent < n && $urandom_range(0, 1) == 1) : (sent < n);
            tick(1'b0, 8'h00, 8'h00, v, word(base, sent), rr);
            cyc++;
            if (o_done) begin
                check("done_count", 32'(nw), 32'(n));
                check("done_latency", 32'(cyc), 32'(last_wr + 1));
                check("done_hs", 32'(sent), 32'(n));
                finished = 1;
            end else begin
                exp_wr = (occ > 0) && (!rr || st == Stall);
                check("busy", o_busy, 1'b1);
                check("in_ready", o_inReady, (occ < Depth) && (rem_in > 0));
                check("write_en", o_write_en, exp_wr);
                check("read_en", o_read_en, rr && !exp_wr);
                hs = v && o_inReady;
                if (o_write_en) begin
                    check("wr_addr", o_writeAddr, 8'(base + 8'(nw)));
                    check("wr_data", o_writeData, word(base, nw));
                    nw++;
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                    st = 0;
                    if (abort_after != 0 && nw == abort_after) begin
                        n_hs = sent + int'(hs);
                        return;
                    end
                end else if (occ > 0 && rr && st < Stall) begin
                    st++;
                end
                if (hs) begin
                    sent++;
                    rem_in--;
                end
                occ = occ + int'(hs) - int'(o_write_en);
                if (occ > max_occ) max_occ = occ;
            end
        end
        if (!finished) check("timeout", 1'b0, 1'b1);
        n_hs = sent;
        tick(1'b0, 8'h00, 8'h00, mode == 3, word(base, sent), 1'b0);
        check("post_done", o_done, 1'b0);
        check("post_busy", o_busy, 1'b0);
        check("post_ready", o_inReady, 1'b0);
    endtask

    initial begin
        int fw, mo, hs;
        // Reset state: everything low except the read grant, which follows the request.
        rst = 1'b0;
        i_readReq = 1'b1;
        #1;
        check("rst_read_en", o_read_en, 1'b1);
        check("rst_write_en", o_write_en, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_ready", o_inReady, 1'b0);
        check("rst_addr", o_writeAddr, 8'h00);
        repeat (3) @(posedge i_fire);
        @(negedge i_fire);
        rst = 1'b1;

        // Basic fill: first write the cycle after the first push.
        run_fill(8'h10, 8'd4, 0, 0, fw, mo, hs);
        check("basic_first_wr", 32'(fw), 32'd2);

        // Wrap through 0xFF with len=0 and extra valid words that must be refused.
        run_fill(8'hFE, 8'd0, 3, 0, fw, mo, hs);
        check("wrap_handshakes", 32'(hs), 32'd256);

        // Starvation: one buffered word waits out 16 blocked cycles, writes on the 17th.
        run_fill(8'h30, 8'd1, 1, 0, fw, mo, hs);
        check("starve_first_wr", 32'(fw), 32'd18);

        // Backpressure: reads always asserted, buffer fills to depth and drains by force.
        run_fill(8'h50, 8'd8, 1, 0, fw, mo, hs);
        check("bp_max_occ", 32'(mo), 32'd4);

        // Random read/valid mix.
        run_fill(8'h80, 8'd32, 2, 0, fw, mo, hs);

        // Reset mid-fill after 3 of 6 writes.
        run_fill(8'h20, 8'd6, 0, 3, fw, mo, hs);
        rst = 1'b0;
        i_readReq = 1'b1;
        #1;
        check("abort_write_en", o_write_en, 1'b0);
        check("abort_read_en", o_read_en, 1'b1);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        check("abort_ready", o_inReady, 1'b0);
        check("abort_data", o_writeData, 72'h0);
        @(negedge i_fire);
        rst = 1'b1;
        i_readReq = 1'b0;
        #1;
        check("abort_idle_wr", o_write_en, 1'b0);
        run_fill(8'h40, 8'd2, 0, 0, fw, mo, hs);
        check("refill_first_wr", 32'(fw), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
